// File: rtl/mem_stage_wb_pkg.sv
// Shared definitions for the memory-access stage: size codes and control-bus bit positions.
package mem_stage_wb_pkg;

  // Access size codes carried on mem_size_reg; 2'b11 is handled as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bit positions of the memory controls within the 22-bit decoded control bus.
  localparam int unsigned CTRL_W         = 22;
  localparam int unsigned CTRL_SIZE_LO   = 5;
  localparam int unsigned CTRL_SIZE_HI   = 6;
  localparam int unsigned CTRL_RW        = 4;
  localparam int unsigned CTRL_SE        = 3;
  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_RF_ENABLE = 9;
  localparam int unsigned CTRL_LOAD      = 10;

endpackage

// File: rtl/data_ram_be.sv
// Byte-addressed big-endian data RAM: size-masked write, 4-byte combinational read.
module data_ram_be
  import mem_stage_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Lane addresses wrap naturally through ADDR_W-bit arithmetic.
  logic [ADDR_W-1:0] addr1, addr2, addr3;
  assign addr1 = addr + ADDR_W'(1);
  assign addr2 = addr + ADDR_W'(2);
  assign addr3 = addr + ADDR_W'(3);

  // Big-endian read: lowest address lands in the most significant byte.
  assign rdata = {mem[addr], mem[addr1], mem[addr2], mem[addr3]};

  // Write only the lanes covered by the access size; other bytes untouched.
  always_ff @(posedge clk) begin
    if (we) begin
      case (size)
        SIZE_BYTE: begin
          mem[addr] <= wdata[7:0];
        end
        SIZE_HALF: begin
          mem[addr]  <= wdata[15:8];
          mem[addr1] <= wdata[7:0];
        end
        default: begin
          mem[addr]  <= wdata[31:24];
          mem[addr1] <= wdata[23:16];
          mem[addr2] <= wdata[15:8];
          mem[addr3] <= wdata[7:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_wb.sv
// Memory-access stage with alignment check, load extension and embedded MEM/WB register.
module mem_stage_wb
  import mem_stage_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  mem_size_reg,
  input  logic        mem_se_reg,
  input  logic        mem_rw_reg,
  input  logic        mem_enable_reg,
  input  logic        load_instr_reg,
  input  logic        rf_enable_reg,
  output logic [31:0] mem_load_data,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_rf_enable,
  output logic        wb_load,
  output logic        misalign_err
);

  logic [ADDR_W-1:0] addr;
  logic              misaligned;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_addr_hi;

  assign addr           = ex_result[ADDR_W-1:0];
  assign unused_addr_hi = ^ex_result[31:ADDR_W];

  // Flag halfword accesses on odd addresses and word accesses off a 4-byte boundary.
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_reg)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr[0];
      default:   misaligned = (addr[1:0] != 2'b00);
    endcase
    misaligned = misaligned & mem_enable_reg;
  end

  assign ram_we = mem_enable_reg & mem_rw_reg & ~misaligned & ~stall & ~flush;

  data_ram_be #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .size  (mem_size_reg),
    .addr  (addr),
    .wdata (ex_store_data),
    .rdata (ram_rdata)
  );

  // Select and extend the addressed bytes; quiet zero when no access is active.
  always_comb begin
    mem_load_data = '0;
    if (mem_enable_reg) begin
      case (mem_size_reg)
        SIZE_BYTE: mem_load_data = {{24{mem_se_reg & ram_rdata[31]}}, ram_rdata[31:24]};
        SIZE_HALF: mem_load_data = {{16{mem_se_reg & ram_rdata[31]}}, ram_rdata[31:16]};
        default:   mem_load_data = ram_rdata;
      endcase
    end
  end

  logic [31:0] wb_data_d, wb_data_q;
  logic [4:0]  wb_rd_d, wb_rd_q;
  logic        wb_rf_enable_d, wb_rf_enable_q;
  logic        wb_load_d, wb_load_q;
  logic        misalign_err_d, misalign_err_q;

  // MEM/WB next state: flush inserts a bubble and beats stall, stall holds everything.
  always_comb begin
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_rf_enable_d = wb_rf_enable_q;
    wb_load_d      = wb_load_q;
    misalign_err_d = misalign_err_q;
    if (flush) begin
      wb_data_d      = '0;
      wb_rd_d        = '0;
      wb_rf_enable_d = 1'b0;
      wb_load_d      = 1'b0;
      misalign_err_d = 1'b0;
    end else if (!stall) begin
      wb_data_d      = load_instr_reg ? mem_load_data : ex_result;
      wb_rd_d        = ex_rd;
      wb_rf_enable_d = rf_enable_reg & ~misaligned;
      wb_load_d      = load_instr_reg;
      misalign_err_d = misaligned;
    end
  end

  // MEM/WB register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_rf_enable_q <= 1'b0;
      wb_load_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_rf_enable_q <= wb_rf_enable_d;
      wb_load_q      <= wb_load_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_rf_enable = wb_rf_enable_q;
  assign wb_load      = wb_load_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
Memory-access stage placed directly downstream of the EX/MEM pipeline register. It consumes the decoded memory controls (size, sign-extend, read/write, enable, load, rf_enable) together with the ALU result and store data. It performs byte, halfword and word accesses on an internal byte-addressed big-endian data RAM, then captures the write-back value in an embedded MEM/WB pipeline register. Alignment checking, stall and flush are handled in this block.

Parameters:
DEPTH, 256, data RAM size in bytes; must be a power of two.
ADDR_W, 8, log2(DEPTH); only ex_result[ADDR_W-1:0] addresses the RAM.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold MEM/WB register and suppress the RAM write
flush  input  1  kill the instruction in MEM; insert a bubble into MEM/WB
ex_result  input  32  ALU result: memory address, or non-load write-back value
ex_store_data  input  32  store data (rt value)
ex_rd  input  5  destination register
mem_size_reg  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
mem_se_reg  input  1  1 = sign-extend byte/halfword loads
mem_rw_reg  input  1  1 = write, 0 = read
mem_enable_reg  input  1  memory access valid
load_instr_reg  input  1  instruction is a load
rf_enable_reg  input  1  instruction writes the register file
mem_load_data  output  32  combinational load result (for forwarding)
wb_data  output  32  registered write-back data
wb_rd  output  5  registered destination
wb_rf_enable  output  1  registered RF write enable
wb_load  output  1  registered load flag
misalign_err  output  1  registered; high for one cycle per misaligned access

Behaviour:
- Reset (async, clk domain): wb_data=0, wb_rd=0, wb_rf_enable=0, wb_load=0, misalign_err=0. RAM contents are not reset.
- Address a = ex_result[ADDR_W-1:0]. Addresses wrap modulo DEPTH. Byte lanes also wrap, so a+1 of DEPTH-1 is 0.
- Big-endian layout: a word at a is {mem[a],mem[a+1],mem[a+2],mem[a+3]}; a halfword is {mem[a],mem[a+1]}.
- Misaligned access:
  - Definition: mem_enable_reg=1 and either halfword with a[0]=1, or word/11 with a[1:0]!=0.
  - No RAM write occurs.
  - The MEM/WB capture forces wb_rf_enable=0.
  - misalign_err=1 for the next cycle.
- RAM read is combinational. mem_load_data is:
  - byte: mem[a], sign- or zero-extended per mem_se_reg.
  - halfword: {mem[a],mem[a+1]}, sign- or zero-extended per mem_se_reg.
  - word: all 4 bytes.
  - 0 when mem_enable_reg=0.
- RAM write on posedge when all hold: mem_enable_reg=1, mem_rw_reg=1, aligned, stall=0, flush=0.
  - byte writes ex_store_data[7:0].
  - halfword writes [15:8]→a and [7:0]→a+1.
  - word writes [31:24]→a … [7:0]→a+3.
  - Other bytes are untouched.
- MEM/WB capture on posedge, in priority order:
  - flush: all wb_* outputs and misalign_err become 0 (bubble). Flush wins over stall.
  - else stall: all outputs hold, misalign_err included.
  - else: wb_data = load_instr_reg ? mem_load_data : ex_result; wb_rd = ex_rd; wb_load = load_instr_reg; wb_rf_enable = rf_enable_reg & ~misaligned; misalign_err = misaligned.
- Latency:
  - A store is visible to a load issued in the following cycle. Read-after-write ordering comes from the sequential pipeline.
  - Load data appears on wb_data one clock after the instruction is in MEM.
- mem_rw_reg=1 with load_instr_reg=1 is illegal. Write-back then uses current RAM contents (pre-write). No check is made.
- If reset asserts mid-stream, outputs clear immediately. RAM keeps its contents.

Decomposition:
- Shared package holds:
  - Size codes: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - Control-bit indices of the 22-bit control bus: size [6:5], rw 4, se 3, enable 0, rf_enable 9, load 10.
- One sub-module: data_ram_be, a byte-addressed big-endian RAM with a size-masked write and a 4-byte combinational read port.
- Extension, alignment and the MEM/WB register stay in the top module.

Test Plan:
- Store word 0xDEADBEEF at a=0x10, then load word from 0x10 → wb_data=0xDEADBEEF, wb_rf_enable=1 and wb_load=1 one cycle later.
- Load byte a=0x10 with se=1 → 0xFFFFFFDE; se=0 → 0x000000DE. Load half a=0x12 with se=1 → 0xFFFFBEEF.
- Store byte 0x55 at a=0x11, then load word 0x10 → 0xDE55BEEF.
- Word store at a=0x21 → RAM unchanged, misalign_err=1 for exactly one cycle, wb_rf_enable=0. Half load at a=0x13 also flags.
- stall=1 during a store → no write; wb_* outputs hold. Stall and flush together → bubble (all zero) and no write.
- Non-load ALU op with ex_result=0x1234, rd=7 → wb_data=0x1234, wb_rd=7. Assert reset mid-sequence → outputs 0 at once; previously stored data still reads back after reset.
